// File: rtl/draw_rect_fill.sv
// ============================================================================
//  Module      : draw_rect_fill (with span engine draw_line_1d)
//  Description : Filled-rectangle controller; steps a 1-D span engine row by
//                row to emit every pixel of an axis-aligned rectangle in
//                raster order. Optional macro DRAW_RECT_FILL_SORT_EN sorts the
//                corners on latch so any corner order is legal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_line_1d #(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] x1,
    output logic signed [CORDW-1:0] x,
    output logic                    drawing,
    output logic                    done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [CORDW-1:0] r_x;
    logic signed [CORDW-1:0] r_xb;
    logic                    w_last;

    assign w_last = (r_x == r_xb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Position registers carry no reset; they are only meaningful while drawing.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_x  <= x0;
            r_xb <= x1;
        end else if (r_state == S_DRAW && oe && !w_last) begin
            r_x  <= r_x + CORDW'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAW;
            S_DRAW:  if (oe && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign x       = r_x;
    assign drawing = (r_state == S_DRAW) && oe;
    assign done    = (r_state == S_DONE);

endmodule

module draw_rect_fill #(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_INIT       = 2'd1,
        S_LINE_START = 2'd2,
        S_LINE_DRAW  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [CORDW-1:0] r_xa;
    logic signed [CORDW-1:0] r_xb;
    logic signed [CORDW-1:0] r_ya;
    logic signed [CORDW-1:0] r_yb;
    logic signed [CORDW-1:0] r_y;
    logic                    r_busy;
    logic                    r_done;
    logic signed [CORDW-1:0] w_xa;
    logic signed [CORDW-1:0] w_xb;
    logic signed [CORDW-1:0] w_ya;
    logic signed [CORDW-1:0] w_yb;
    logic                    w_accept;
    logic                    w_line_start;
    logic                    w_line_done;
    logic                    w_last_row;

`ifdef DRAW_RECT_FILL_SORT_EN
    assign w_xa = (x0 < x1) ? x0 : x1;
    assign w_xb = (x0 < x1) ? x1 : x0;
    assign w_ya = (y0 < y1) ? y0 : y1;
    assign w_yb = (y0 < y1) ? y1 : y0;
`else
    assign w_xa = x0;
    assign w_xb = x1;
    assign w_ya = y0;
    assign w_yb = y1;
`endif

    // The done cycle already reads as IDLE; holding off there makes a start
    // coincident with done land on the following cycle instead.
    assign w_accept   = (r_state == S_IDLE) && start && !r_done;
    assign w_last_row = (r_y == r_yb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) r_busy <= 1'b1;
                end
                S_LINE_DRAW: begin
                    if (w_line_done && w_last_row) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_xa <= w_xa;
            r_xb <= w_xb;
            r_ya <= w_ya;
            r_yb <= w_yb;
        end
        if (r_state == S_INIT) begin
            r_y <= r_ya;
        end else if (r_state == S_LINE_DRAW && w_line_done && !w_last_row) begin
            r_y <= r_y + CORDW'(1);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_line_start = 1'b0;
        case (r_state)
            S_IDLE:       if (w_accept) w_next = S_INIT;
            S_INIT:       w_next = S_LINE_START;
            S_LINE_START: begin
                w_line_start = 1'b1;
                w_next       = S_LINE_DRAW;
            end
            S_LINE_DRAW: begin
                if (w_line_done) w_next = w_last_row ? S_IDLE : S_LINE_START;
            end
            default:      w_next = S_IDLE;
        endcase
    end

    draw_line_1d #(
        .CORDW   (CORDW)
    ) u_span (
        .clk     (clk),
        .rst     (rst),
        .start   (w_line_start),
        .oe      (oe),
        .x0      (r_xa),
        .x1      (r_xb),
        .x       (x),
        .drawing (drawing),
        .done    (w_line_done)
    );

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_fill.sv
// ============================================================================
//  Module      : tb_draw_rect_fill
//  Description : Scoreboard bench for draw_rect_fill; expected pixels and their
//                cycles are queued at start and popped as the DUT draws.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_rect_fill;
    localparam int CORDW = 16;

    typedef struct {
        int x;
        int y;
        int cyc;
    } pix_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    oe = 1'b1;
    logic signed [CORDW-1:0] x0 = '0;
    logic signed [CORDW-1:0] y0 = '0;
    logic signed [CORDW-1:0] x1 = '0;
    logic signed [CORDW-1:0] y1 = '0;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    drawing;
    logic                    busy;
    logic                    done;

    pix_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    draw_rect_fill #(.CORDW(CORDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .oe      (oe),
        .x0      (x0),
        .y0      (y0),
        .x1      (x1),
        .y1      (y1),
        .x       (x),
        .y       (y),
        .drawing (drawing),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Raster-order expectation for corners given in any order (bench sorts).
    task automatic push_rect(input int ax0, input int ay0, input int ax1, input int ay1);
        int xa = (ax0 < ax1) ? ax0 : ax1;
        int xb = (ax0 < ax1) ? ax1 : ax0;
        int ya = (ay0 < ay1) ? ay0 : ay1;
        int yb = (ay0 < ay1) ? ay1 : ay0;
        int w  = xb - xa + 1;
        for (int r = 0; r <= yb - ya; r++) begin
            for (int i = 0; i < w; i++) begin
                pix_t p;
                p.x = xa + i;
                p.y = ya + r;
                p.cyc = 2 + r * (w + 2) + i;
                sb.push_back(p);
            end
        end
    endtask

    // Accept at edge 0, then watch cycles 0..ncyc-1 with optional stall,
    // ignored restart, and mid-run reset.
    task automatic run_rect(input string name, input int ax0, input int ay0,
                            input int ax1, input int ay1, input int done_cyc,
                            input int stall_at, input int stall_len,
                            input int restart_at, input int rst_at, input int ncyc);
        int   npix = 0;
        int   nexp = sb.size();
        logic exp_busy;
        logic exp_done;
        @(negedge clk);
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < ncyc; c++) begin
            oe    = !(c >= stall_at && c < stall_at + stall_len);
            rst   = (c == rst_at);
            start = (c == restart_at);
            if (c == restart_at) begin
                x0 = -16'sd7; y0 = -16'sd7; x1 = 16'sd9; y1 = 16'sd9;
            end
            #1;
            if (drawing) begin
                npix++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_pixel cyc=%0d got (%0d,%0d) required none", name, c, x, y);
                end else begin
                    pix_t e = sb.pop_front();
                    if (int'(x) !== e.x || int'(y) !== e.y || c !== e.cyc) begin
                        n_fail++;
                        $display("FAIL %s pixel got (%0d,%0d)@%0d required (%0d,%0d)@%0d",
                                 name, x, y, c, e.x, e.y, e.cyc);
                    end
                end
            end
            if (rst_at >= 0 && c > rst_at) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
                n_tests++;
                if (drawing !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s drawing_after_rst cyc=%0d got %b required 0", name, c, drawing);
                end
            end else begin
                exp_busy = (c < done_cyc);
                exp_done = (c == done_cyc);
            end
            n_tests++;
            if (busy !== exp_busy || done !== exp_done) begin
                n_fail++;
                $display("FAIL %s busy_done cyc=%0d got busy=%b done=%b required busy=%b done=%b",
                         name, c, busy, done, exp_busy, exp_done);
            end
            @(posedge clk);
            #1;
        end
        oe = 1'b1; start = 1'b0; rst = 1'b0;
        n_tests++;
        if (sb.size() != 0 || npix != nexp) begin
            n_fail++;
            $display("FAIL %s pixel_count got %0d required %0d", name, npix, nexp);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || drawing !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b done=%b drawing=%b required 0 0 0", busy, done, drawing);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        push_rect(3, 3, 3, 3);
        run_rect("pixel1x1", 3, 3, 3, 3, 4, -1, 0, -1, -1, 7);
    endtask

    task automatic test_rect_4x3();
        push_rect(2, 1, 5, 3);
        run_rect("rect4x3", 2, 1, 5, 3, 19, -1, 0, -1, -1, 22);
    endtask

    task automatic test_negative();
        push_rect(-2, -1, 0, 0);
        run_rect("negative", -2, -1, 0, 0, 11, -1, 0, -1, -1, 14);
    endtask

    task automatic test_stall_restart();
        push_rect(2, 1, 5, 3);
        foreach (sb[i]) if (sb[i].cyc >= 9) sb[i].cyc += 3;
        run_rect("stall", 2, 1, 5, 3, 22, 9, 3, 6, -1, 25);
    endtask

    task automatic test_mid_reset();
        push_rect(2, 1, 5, 3);
        while (sb.size() > 0 && sb[sb.size()-1].cyc > 9) void'(sb.pop_back());
        run_rect("midrst", 2, 1, 5, 3, 1000, -1, 0, -1, 9, 20);
        push_rect(0, 0, 1, 0);
        run_rect("after_rst", 0, 0, 1, 0, 5, -1, 0, -1, -1, 8);
    endtask

    task automatic test_sort();
`ifdef DRAW_RECT_FILL_SORT_EN
        push_rect(5, 7, 3, 6);
        run_rect("sort", 5, 7, 3, 6, 11, -1, 0, -1, -1, 14);
`else
        push_rect(3, 6, 5, 7);
        run_rect("ordered", 3, 6, 5, 7, 11, -1, 0, -1, -1, 14);
`endif
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_rect_4x3();
        test_negative();
        test_stall_restart();
        test_mid_reset();
        test_sort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
